nn_frame_loader: RTL and testbench
==================================

// Module: nn_frame_loader
// PURPOSE
//  Consumes the 32-bit hex word stream produced by the file-reader stimulus stage.
//  Parses it into tagged frames (header + N payload words) and buffers payload in a
//  FWFT FIFO. Presents frames to the NN pipeline with first/last markers.
//  Flags truncated and empty frames. Guarantees the final stream word is delivered.
// PARAMETERS
//  DATA_W  32  payload word width
//  DEPTH   8   FIFO entries; power of 2, >=2
//  LEN_W   16  width of header length field and frame counter
// PORTS
//  clk          in   1        clock, all logic on posedge
//  rst          in   1        synchronous reset, active high
//  in_valid     in   1        upstream word valid
//  in_data      in   DATA_W   upstream word
//  in_last      in   1        marks final word of stream (EOF)
//  in_ready     out  1        loader accepts word this cycle
//  out_valid    out  1        FIFO head valid
//  out_data     out  DATA_W   payload word at FIFO head
//  out_tag      out  8        frame tag of head word
//  out_first    out  1        head is first payload word of its frame
//  out_last     out  1        head is last payload word of its frame
//  out_ready    in   1        downstream pops head when out_valid&out_ready
//  fifo_level   out  log2(DEPTH)+1  entries currently held
//  frame_count  out  LEN_W    frames fully popped (last word popped), wraps
//  err_trunc    out  1        1-cycle pulse: in_last arrived before frame complete
//  err_zero     out  1        1-cycle pulse: header with length 0 dropped
//  stream_done  out  1        sticky: in_last consumed and FIFO empty
// BEHAVIOUR
//  Reset: state=S_HDR; FIFO empty; out_valid=0, fifo_level=0, frame_count=0,
//   err_* =0, stream_done=0, eos flag=0. Reset mid-frame discards FIFO and header.
//  Header word: [31:24]=tag, [23:16] ignored, [LEN_W-1:0]=length N.
//  FSM:
//   S_HDR: in_ready=~eos. On accept: latch tag, remaining=N, first_pend=1.
//    N==0 -> pulse err_zero, stay S_HDR. N>0 & ~in_last -> S_PAY.
//    in_last on header -> pulse err_trunc, set eos, stay S_HDR.
//   S_PAY: in_ready = ~full (registered full only; no comb path from out_ready).
//    On accept: push {tag, first_pend, last_bit, data}; first_pend<=0; remaining-=1.
//    last_bit = (remaining==1) | in_last.
//    remaining==1 -> S_HDR. in_last with remaining>1 -> pulse err_trunc.
//    in_last (any) -> set eos, S_HDR; no further input accepted until reset.
//  FIFO: FWFT, entry width DATA_W+10. Word pushed in cycle t visible on out_* at
//   t+1. Push and pop in same cycle: both happen, level unchanged. Push when full
//   impossible (in_ready=0). Pointers wrap modulo DEPTH; level saturates 0..DEPTH.
//  out_* hold stable while out_valid & ~out_ready.
//  frame_count += 1 on cycle a word with out_last=1 is popped; wraps 2^LEN_W-1 -> 0.
//  stream_done <= 1 when eos=1 & level==0 & no push this cycle; sticky until rst.
//  Frames may overlap in FIFO: next header accepted while prior payload queued.
//  Header words never occupy FIFO slots; header accept costs one cycle.
// TESTING
//  1 Hdr 0xA1000003, words 11,22,33, out_ready=1 -> 3 outs tag A1; first on 11,
//    last on 33; frame_count=1; each word out 1 cycle after accept.
//  2 Hdr 0x05000010 (N=16), DEPTH=8, out_ready=0 -> in_ready drops after 8 pushes,
//    level=8; raise out_ready -> all 16 delivered in order, no loss/dup.
//  3 Hdr 0x07000004, 2 words, 2nd with in_last=1 -> err_trunc 1 pulse; 2nd word
//    out_last=1; in_ready stays 0; stream_done=1 after pop.
//  4 Hdr 0x09000000 then hdr 0x0A000001 + 0xBEEF -> err_zero pulse; single out
//    0xBEEF tag 0A first=last=1.
//  5 Final stream word = payload with in_last=1 at exact frame end -> delivered,
//    no err_trunc, stream_done=1.
//  6 rst high during S_PAY with level=5 -> next cycle level=0, out_valid=0,
//    frame_count=0, FSM S_HDR.

Source files
------------

// File: rtl/nn_frame_loader_if.sv
// Word-stream handshake bundle between the stimulus reader,
// the frame loader and the downstream NN pipeline.
interface nn_frame_loader_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [7:0]        out_tag;
    logic              out_first;
    logic              out_last;
    logic              out_ready;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data,
        input  out_tag, out_first, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data,
        output out_tag, out_first, out_last
    );
endinterface

// File: rtl/nn_frame_loader.sv
// Splits the word stream into tagged frames and buffers the
// payload in a first-word-fall-through FIFO with frame markers.
module nn_frame_loader #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int LEN_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    nn_frame_loader_if.slave       bus,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [LEN_W-1:0]       frame_count,
    output logic                   err_trunc,
    output logic                   err_zero,
    output logic                   stream_done
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = DATA_W + 10;

    typedef enum logic {S_HDR, S_PAY} state_t;

    state_t           state;
    logic [EW-1:0]    mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LEN_W-1:0] remaining;
    logic [7:0]       tag_q;
    logic             first_pend;
    logic             eos;

    logic             full;
    logic             accept;
    logic             push;
    logic             pop;
    logic             last_bit;
    logic [LEN_W-1:0] hdr_len;
    logic [EW-1:0]    head;

    // full comes from the registered level, so in_ready never
    // depends combinationally on out_ready
    assign full     = fifo_level == (AW+1)'(DEPTH);
    assign accept   = bus.in_valid & bus.in_ready;
    assign push     = accept & (state == S_PAY);
    assign pop      = bus.out_valid & bus.out_ready;
    assign hdr_len  = bus.in_data[LEN_W-1:0];
    assign last_bit = (remaining == LEN_W'(1)) | bus.in_last;
    assign head     = mem[rd_ptr];

    assign bus.in_ready  = (state == S_HDR) ? ~eos : ~full;
    assign bus.out_valid = fifo_level != '0;
    assign bus.out_tag   = head[EW-1 -: 8];
    assign bus.out_first = head[DATA_W+1];
    assign bus.out_last  = head[DATA_W];
    assign bus.out_data  = head[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= {tag_q, first_pend, last_bit,
                            bus.in_data};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_HDR;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_level  <= '0;
            frame_count <= '0;
            remaining   <= '0;
            tag_q       <= '0;
            first_pend  <= 1'b0;
            eos         <= 1'b0;
            err_trunc   <= 1'b0;
            err_zero    <= 1'b0;
            stream_done <= 1'b0;
        end else begin
            err_trunc <= 1'b0;
            err_zero  <= 1'b0;

            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
                if (bus.out_last)
                    frame_count <= frame_count + LEN_W'(1);
            end
            if (push)
                wr_ptr <= wr_ptr + AW'(1);

            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: ;
            endcase

            if (eos && fifo_level == '0 && !push)
                stream_done <= 1'b1;

            if (accept) begin
                unique case (state)
                    S_HDR: begin
                        tag_q      <= bus.in_data[DATA_W-1 -: 8];
                        remaining  <= hdr_len;
                        first_pend <= 1'b1;
                        if (hdr_len == '0)
                            err_zero <= 1'b1;
                        if (bus.in_last) begin
                            err_trunc <= 1'b1;
                            eos       <= 1'b1;
                        end else if (hdr_len != '0) begin
                            state <= S_PAY;
                        end
                    end
                    S_PAY: begin
                        first_pend <= 1'b0;
                        remaining  <= remaining - LEN_W'(1);
                        if (bus.in_last &&
                            remaining > LEN_W'(1))
                            err_trunc <= 1'b1;
                        if (bus.in_last)
                            eos <= 1'b1;
                        if (bus.in_last ||
                            remaining == LEN_W'(1))
                            state <= S_HDR;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_nn_frame_loader.sv
// Vector table, corner sequences and randomized streams checked
// against a queue-based frame model of the loader.
module tb_nn_frame_loader;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  fifo_level;
    logic [15:0] frame_count;
    logic        err_trunc;
    logic        err_zero;
    logic        stream_done;

    nn_frame_loader_if #(.DATA_W(32)) bus ();

    nn_frame_loader #(
        .DATA_W(32), .DEPTH(DEPTH), .LEN_W(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .fifo_level (fifo_level),
        .frame_count(frame_count),
        .err_trunc  (err_trunc),
        .err_zero   (err_zero),
        .stream_done(stream_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    function automatic void chk(string n, logic [31:0] a,
                                logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, a, e);
        end
    endfunction

    typedef struct {
        logic [31:0] d;
        logic [7:0]  t;
        logic        f;
        logic        l;
    } ent_t;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } src_t;

    // Model: expected FIFO contents plus parser position
    ent_t        mq[$];
    logic        m_hdr, m_eos, m_first, m_done;
    logic        m_et, m_ez;
    logic [7:0]  m_tag;
    logic [15:0] m_rem, m_frames;

    src_t        src[$];
    int          idx;

    logic        s_ir, s_ov, s_f, s_la, s_ez;
    logic [31:0] s_od;
    logic [7:0]  s_tag;

    function automatic void model_reset();
        mq.delete();
        m_hdr = 1; m_eos = 0; m_first = 0; m_done = 0;
        m_et = 0; m_ez = 0; m_tag = 0; m_rem = 0;
        m_frames = 0;
    endfunction

    task automatic do_reset();
        rst = 1;
        bus.in_valid = 0; bus.in_data = 0;
        bus.in_last = 0; bus.out_ready = 0;
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic step(input logic v, input logic [31:0] d,
                        input logic l, input logic r,
                        output logic acc);
        logic ir, psh, pop, nd;
        ent_t e;
        bus.in_valid = v; bus.in_data = d;
        bus.in_last = l; bus.out_ready = r;
        @(negedge clk);
        s_ir = bus.in_ready; s_ov = bus.out_valid;
        s_od = bus.out_data; s_tag = bus.out_tag;
        s_f = bus.out_first; s_la = bus.out_last;
        s_ez = err_zero;
        ir = m_hdr ? !m_eos : (mq.size() < DEPTH);
        chk("in_ready", bus.in_ready, ir);
        chk("out_valid", bus.out_valid, mq.size() != 0);
        if (mq.size() != 0) begin
            chk("out_data", bus.out_data, mq[0].d);
            chk("out_tag", bus.out_tag, mq[0].t);
            chk("out_first", bus.out_first, mq[0].f);
            chk("out_last", bus.out_last, mq[0].l);
        end
        chk("fifo_level", fifo_level, mq.size());
        chk("frame_count", frame_count, m_frames);
        chk("err_trunc", err_trunc, m_et);
        chk("err_zero", err_zero, m_ez);
        chk("stream_done", stream_done, m_done);
        @(posedge clk);
        acc = v & ir;
        psh = acc & !m_hdr;
        pop = r & (mq.size() != 0);
        nd = m_done | (m_eos & (mq.size() == 0) & !psh);
        m_et = 0; m_ez = 0;
        if (pop) begin
            if (mq[0].l) m_frames++;
            void'(mq.pop_front());
        end
        if (acc && m_hdr) begin
            m_tag = d[31:24]; m_rem = d[15:0]; m_first = 1;
            if (d[15:0] == 0) m_ez = 1;
            if (l) begin
                m_et = 1; m_eos = 1;
            end else if (d[15:0] != 0) begin
                m_hdr = 0;
            end
        end else if (acc) begin
            e.d = d; e.t = m_tag; e.f = m_first;
            e.l = (m_rem == 1) | l;
            mq.push_back(e);
            m_first = 0;
            if (l && m_rem > 1) m_et = 1;
            if (l) m_eos = 1;
            if (l || m_rem == 1) m_hdr = 1;
            m_rem--;
        end
        m_done = nd;
        #1;
    endtask

    task automatic run_cycles(input int n, input int pv,
                              input int pr);
        logic v, a;
        for (int c = 0; c < n; c++) begin
            v = (idx < src.size()) &&
                ($urandom_range(99) < pv);
            step(v, v ? src[idx].d : $urandom,
                 v ? src[idx].l : 1'b0,
                 $urandom_range(99) < pr, a);
            if (a) idx++;
        end
    endtask

    task automatic drain(input string n, input int pv,
                         input int pr, input int maxc);
        logic v, a;
        int c;
        for (c = 0; c < maxc; c++) begin
            if (idx >= src.size() && mq.size() == 0) break;
            v = (idx < src.size()) &&
                ($urandom_range(99) < pv);
            step(v, v ? src[idx].d : $urandom,
                 v ? src[idx].l : 1'b0,
                 $urandom_range(99) < pr, a);
            if (a) idx++;
        end
        chk({n, "_drain_timeout"}, c < maxc, 1);
    endtask

    function automatic void add(logic [31:0] d, logic l);
        src_t s;
        s.d = d; s.l = l;
        src.push_back(s);
    endfunction

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        ir, ov;
        logic [31:0] od;
        logic [7:0]  tag;
        logic        f, la, ez;
    } vec_t;

    vec_t tbl[11];

    initial begin
        logic a;
        int nf, n, cut;

        tbl[0]  = '{1, 32'hA1000003, 1, 0, 0, 0, 0, 0, 0};
        tbl[1]  = '{1, 32'h00000011, 1, 0, 0, 0, 0, 0, 0};
        tbl[2]  = '{1, 32'h00000022, 1, 1, 32'h11,
                    8'hA1, 1, 0, 0};
        tbl[3]  = '{1, 32'h00000033, 1, 1, 32'h22,
                    8'hA1, 0, 0, 0};
        tbl[4]  = '{0, 32'h0, 1, 1, 32'h33, 8'hA1, 0, 1, 0};
        tbl[5]  = '{0, 32'h0, 1, 0, 0, 0, 0, 0, 0};
        tbl[6]  = '{1, 32'h09000000, 1, 0, 0, 0, 0, 0, 0};
        tbl[7]  = '{1, 32'h0A000001, 1, 0, 0, 0, 0, 0, 1};
        tbl[8]  = '{1, 32'h0000BEEF, 1, 0, 0, 0, 0, 0, 0};
        tbl[9]  = '{0, 32'h0, 1, 1, 32'hBEEF, 8'h0A, 1, 1, 0};
        tbl[10] = '{0, 32'h0, 1, 0, 0, 0, 0, 0, 0};

        do_reset();
        chk("rst_level", fifo_level, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_frames", frame_count, 0);
        chk("rst_done", stream_done, 0);
        chk("rst_errs", {err_trunc, err_zero}, 0);
        chk("rst_ready", bus.in_ready, 1);

        for (int i = 0; i < 11; i++) begin
            step(tbl[i].v, tbl[i].d, 1'b0, 1'b1, a);
            chk($sformatf("tbl%0d_ir", i), s_ir, tbl[i].ir);
            chk($sformatf("tbl%0d_ov", i), s_ov, tbl[i].ov);
            chk($sformatf("tbl%0d_ez", i), s_ez, tbl[i].ez);
            if (tbl[i].ov) begin
                chk($sformatf("tbl%0d_od", i), s_od, tbl[i].od);
                chk($sformatf("tbl%0d_tag", i), s_tag,
                    tbl[i].tag);
                chk($sformatf("tbl%0d_f", i), s_f, tbl[i].f);
                chk($sformatf("tbl%0d_la", i), s_la, tbl[i].la);
            end
        end
        chk("tbl_frames", frame_count, 2);

        // Backpressure: 16-word frame through an 8-deep FIFO
        do_reset();
        src.delete(); idx = 0;
        add(32'h05000010, 0);
        for (int i = 0; i < 16; i++) add(32'h100 + i, 0);
        run_cycles(12, 100, 0);
        chk("bp_accepted", idx, 9);
        chk("bp_level", fifo_level, 8);
        chk("bp_ready", bus.in_ready, 0);
        drain("bp", 100, 100, 60);
        chk("bp_frames", frame_count, 1);

        // Truncated frame ends the stream
        do_reset();
        src.delete(); idx = 0;
        add(32'h07000004, 0); add(32'h1, 0); add(32'h2, 1);
        run_cycles(3, 100, 0);
        chk("tr_pulse", err_trunc, 1);
        chk("tr_ready", bus.in_ready, 0);
        step(0, 0, 0, 0, a);
        chk("tr_pulse_end", err_trunc, 0);
        drain("tr", 100, 100, 20);
        run_cycles(3, 0, 100);
        chk("tr_done", stream_done, 1);
        chk("tr_frames", frame_count, 1);

        // EOF exactly at frame end
        do_reset();
        src.delete(); idx = 0;
        add(32'h01000002, 0); add(32'hAA, 0); add(32'hBB, 1);
        drain("eof", 100, 100, 20);
        run_cycles(3, 0, 100);
        chk("eof_done", stream_done, 1);
        chk("eof_frames", frame_count, 1);

        // Reset in the middle of a payload
        do_reset();
        src.delete(); idx = 0;
        add(32'h01000001, 0); add(32'h77, 0);
        add(32'h03000009, 0);
        for (int i = 0; i < 5; i++) add(32'h200 + i, 0);
        drain("mr_pre", 100, 100, 20);
        src.delete(); idx = 0;
        add(32'h03000009, 0);
        for (int i = 0; i < 5; i++) add(32'h200 + i, 0);
        run_cycles(6, 100, 0);
        chk("mr_level", fifo_level, 5);
        chk("mr_frames_pre", frame_count, 1);
        do_reset();
        chk("mr_level0", fifo_level, 0);
        chk("mr_valid0", bus.out_valid, 0);
        chk("mr_frames0", frame_count, 0);
        chk("mr_hdr", bus.in_ready, 1);
        src.delete(); idx = 0;
        add(32'h02000001, 0); add(32'h55, 0);
        drain("mr_post", 100, 100, 20);

        // Randomized streams, some cut short mid-frame
        for (int r = 0; r < 6; r++) begin
            do_reset();
            src.delete(); idx = 0;
            nf = $urandom_range(2, 6);
            for (int f = 0; f < nf; f++) begin
                n = $urandom_range(0, 10);
                add({8'($urandom), 8'($urandom), 16'(n)}, 0);
                for (int w = 0; w < n; w++) add($urandom, 0);
            end
            if (r % 2 == 1) begin
                cut = $urandom_range(1, src.size());
                while (src.size() > cut) void'(src.pop_back());
            end
            src[src.size()-1].l = 1;
            drain($sformatf("rnd%0d", r), 70, 60, 2000);
            run_cycles(3, 0, 100);
            chk($sformatf("rnd%0d_done", r), stream_done, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
